// File: rtl/run_dump_ctrl_if.sv
// Bundled run/dump control, data-memory read port and dump stream for run_dump_ctrl.
// dump stream: a word transfers on any rising edge where dump_valid && dump_ready; once dump_valid rises, dump_valid/dump_addr/dump_data hold until that transfer.
interface run_dump_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_addr;
  logic              cpu_fin;
  logic              cpu_run;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic [CNT_W-1:0]  cycle_count;
  logic              done;
  logic              timeout;
  logic [2:0]        fsm_state;

  modport master (
    output start, cfg_we, cfg_idx, cfg_addr, cpu_fin, rd_data, dump_ready,
    input  cpu_run, rd_en, rd_addr, dump_valid, dump_addr, dump_data,
           cycle_count, done, timeout, fsm_state
  );

  modport slave (
    input  start, cfg_we, cfg_idx, cfg_addr, cpu_fin, rd_data, dump_ready,
    output cpu_run, rd_en, rd_addr, dump_valid, dump_addr, dump_data,
           cycle_count, done, timeout, fsm_state
  );
endinterface

// File: rtl/run_dump_ctrl.sv
// Run/dump sequencer: releases the core, counts run cycles with a watchdog, then streams table-selected memory words.
// Optional DUMP_CKSUM_EN appends an XOR checksum word (address all-ones) after the last table word.
module run_dump_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_DUMP = 4,
  parameter int IDX_W    = 4,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1024
) (
  input logic          clk,
  input logic          rst,
  run_dump_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN, RD, WT, OUT, DONE} state_t;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DUMP - 1);

  state_t            state;
  logic [ADDR_W-1:0] dump_tab [NUM_DUMP];
  logic [IDX_W-1:0]  idx;
  logic              cfg_ok;
  logic              last_entry;
`ifdef DUMP_CKSUM_EN
  logic [DATA_W-1:0] cksum;
  logic              ck_word;
`endif

  assign cfg_ok = bus.cfg_we && (state == IDLE || state == DONE) &&
                  (int'(bus.cfg_idx) < NUM_DUMP);
  assign last_entry    = (idx == IDX_LAST);
  assign bus.fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      bus.cpu_run     <= 1'b0;
      bus.rd_en       <= 1'b0;
      bus.rd_addr     <= '0;
      bus.dump_valid  <= 1'b0;
      bus.dump_addr   <= '0;
      bus.dump_data   <= '0;
      bus.cycle_count <= '0;
      bus.done        <= 1'b0;
      bus.timeout     <= 1'b0;
      for (int i = 0; i < NUM_DUMP; i++) dump_tab[i] <= ADDR_W'(i);
`ifdef DUMP_CKSUM_EN
      cksum   <= '0;
      ck_word <= 1'b0;
`endif
    end else begin
      // Table writes land in the same edge as a start, so the run sees them.
      if (cfg_ok) dump_tab[bus.cfg_idx] <= bus.cfg_addr;

      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state           <= RUN;
            bus.cpu_run     <= 1'b1;
            bus.cycle_count <= '0;
            bus.done        <= 1'b0;
            bus.timeout     <= 1'b0;
            idx             <= '0;
`ifdef DUMP_CKSUM_EN
            cksum   <= '0;
            ck_word <= 1'b0;
`endif
          end
        end
        RUN: begin
          // The exit cycle does not count, so cycle_count freezes at the fin/watchdog value.
          if (bus.cpu_fin || bus.cycle_count == CNT_W'(TIMEOUT)) begin
            bus.timeout <= !bus.cpu_fin;
            bus.cpu_run <= 1'b0;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= dump_tab[idx];
            state       <= RD;
          end else if (bus.cycle_count != '1) begin
            bus.cycle_count <= bus.cycle_count + CNT_W'(1);
          end
        end
        RD: begin
          bus.rd_en <= 1'b0;
          state     <= WT;
        end
        WT: begin
          bus.dump_valid <= 1'b1;
          state          <= OUT;
`ifdef DUMP_CKSUM_EN
          if (ck_word) begin
            bus.dump_data <= cksum;
            bus.dump_addr <= '1;
          end else begin
            bus.dump_data <= bus.rd_data;
            bus.dump_addr <= bus.rd_addr;
            cksum         <= cksum ^ bus.rd_data;
          end
`else
          bus.dump_data <= bus.rd_data;
          bus.dump_addr <= bus.rd_addr;
`endif
        end
        OUT: begin
          if (bus.dump_ready) begin
            bus.dump_valid <= 1'b0;
`ifdef DUMP_CKSUM_EN
            if (ck_word) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else if (last_entry) begin
              ck_word <= 1'b1;
              state   <= WT;
            end else begin
              idx         <= idx + IDX_ONE;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= dump_tab[idx + IDX_ONE];
              state       <= RD;
            end
`else
            if (last_entry) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              idx         <= idx + IDX_ONE;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= dump_tab[idx + IDX_ONE];
              state       <= RD;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_run_dump_ctrl.sv
// Directed bench for run_dump_ctrl: fin run, watchdog run with stall, reset mid-dump, table reload.
module tb_run_dump_ctrl;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_DUMP = 4;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 32;

  typedef logic [ADDR_W-1:0] tab_t [NUM_DUMP];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_dump_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  run_dump_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_DUMP(NUM_DUMP),
    .IDX_W(IDX_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];

  // Memory model: mem[a] = a*3, one-cycle read latency.
  initial bus.rd_data = '0;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= DATA_W'(bus.rd_addr) * 3;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [IDX_W-1:0] i, input logic [ADDR_W-1:0] a);
    bus.cfg_we = 1'b1; bus.cfg_idx = i; bus.cfg_addr = a;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!bus.cpu_run && n < 20) begin @(negedge clk); n++; end
    check("run_rise", 64'(bus.cpu_run), 64'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.dump_valid && n < 50) begin @(negedge clk); n++; end
    check("wait_valid", 64'(bus.dump_valid), 64'd1);
  endtask

  task automatic push_run(input tab_t t);
    logic [DATA_W-1:0] ck = '0;
    for (int i = 0; i < NUM_DUMP; i++) begin
      exp_addr_q.push_back(t[i]);
      exp_q.push_back(DATA_W'(t[i]) * 3);
      ck ^= DATA_W'(t[i]) * 3;
    end
`ifdef DUMP_CKSUM_EN
    exp_addr_q.push_back('1);
    exp_q.push_back(ck);
`endif
  endtask

  task automatic collect(input int stall_word);
    int w = 0;
    logic [DATA_W-1:0] held;
    while (exp_q.size() > 0) begin
      logic [DATA_W-1:0] ed;
      logic [ADDR_W-1:0] ea;
      ed = exp_q.pop_front();
      ea = exp_addr_q.pop_front();
      wait_valid();
      if (w == stall_word) begin
        bus.dump_ready = 1'b0;
        held = bus.dump_data;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", 64'(bus.dump_valid), 64'd1);
          check("stall_data", 64'(bus.dump_data), 64'(held));
        end
        bus.dump_ready = 1'b1;
      end
      check($sformatf("w%0d_addr", w), 64'(bus.dump_addr), 64'(ea));
      check($sformatf("w%0d_data", w), 64'(bus.dump_data), 64'(ed));
      @(negedge clk);
      check($sformatf("w%0d_vdrop", w), 64'(bus.dump_valid), 64'd0);
      w++;
    end
  endtask

  initial begin
    tab_t t_run, t_rst;
    t_run = '{5'd1, 5'd4, 5'd16, 5'd0};
    t_rst = '{5'd0, 5'd1, 5'd2, 5'd3};
    bus.start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_addr = '0;
    bus.cpu_fin = 1'b0; bus.dump_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_cpu_run", 64'(bus.cpu_run), 64'd0);
    check("rst_rd_en", 64'(bus.rd_en), 64'd0);
    check("rst_valid", 64'(bus.dump_valid), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_timeout", 64'(bus.timeout), 64'd0);
    check("rst_count", 64'(bus.cycle_count), 64'd0);
    check("rst_state", 64'(bus.fsm_state), 64'd0);

    // Run 1: table {1,4,16,0}; entry 3 written together with start; idx 4 write ignored
    cfg_write(4'd0, 5'd1);
    cfg_write(4'd1, 5'd4);
    cfg_write(4'd2, 5'd16);
    cfg_write(4'd4, 5'd9);
    bus.cfg_we = 1'b1; bus.cfg_idx = 4'd3; bus.cfg_addr = 5'd0;
    pulse_start();
    bus.cfg_we = 1'b0;
    wait_run();
    check("r1_count0", 64'(bus.cycle_count), 64'd0);
    cfg_write(4'd0, 5'd7);
    repeat (19) @(negedge clk);
    check("r1_count20", 64'(bus.cycle_count), 64'd20);
    bus.cpu_fin = 1'b1;
    @(negedge clk);
    bus.cpu_fin = 1'b0;
    check("r1_run_drop", 64'(bus.cpu_run), 64'd0);
    check("r1_timeout", 64'(bus.timeout), 64'd0);
    push_run(t_run);
    collect(-1);
    check("r1_done", 64'(bus.done), 64'd1);
    check("r1_count", 64'(bus.cycle_count), 64'd20);
    check("r1_cpu_run", 64'(bus.cpu_run), 64'd0);

    // Run 2: start from DONE, no fin -> watchdog, stall on word 2
    pulse_start();
    wait_run();
    check("r2_done_clr", 64'(bus.done), 64'd0);
    check("r2_count_clr", 64'(bus.cycle_count), 64'd0);
    begin
      int n = 0;
      while (bus.cpu_run && n < 100) begin @(negedge clk); n++; end
    end
    check("r2_wd_drop", 64'(bus.cpu_run), 64'd0);
    check("r2_timeout", 64'(bus.timeout), 64'd1);
    check("r2_count", 64'(bus.cycle_count), 64'(TIMEOUT));
    push_run(t_run);
    collect(2);
    check("r2_done", 64'(bus.done), 64'd1);
    check("r2_timeout_hold", 64'(bus.timeout), 64'd1);

    // Run 3: reset while a word is waiting in OUT
    pulse_start();
    wait_run();
    repeat (3) @(negedge clk);
    bus.cpu_fin = 1'b1;
    @(negedge clk);
    bus.cpu_fin = 1'b0;
    wait_valid();
    bus.dump_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.dump_ready = 1'b1;
    check("mr_valid", 64'(bus.dump_valid), 64'd0);
    check("mr_data", 64'(bus.dump_data), 64'd0);
    check("mr_addr", 64'(bus.dump_addr), 64'd0);
    check("mr_count", 64'(bus.cycle_count), 64'd0);
    check("mr_timeout", 64'(bus.timeout), 64'd0);
    check("mr_state", 64'(bus.fsm_state), 64'd0);

    // Run 4: table back to {0,1,2,3}
    pulse_start();
    wait_run();
    repeat (2) @(negedge clk);
    bus.cpu_fin = 1'b1;
    @(negedge clk);
    bus.cpu_fin = 1'b0;
    check("r4_count", 64'(bus.cycle_count), 64'd2);
    push_run(t_rst);
    collect(-1);
    check("r4_done", 64'(bus.done), 64'd1);
    check("r4_timeout", 64'(bus.timeout), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
